// File: rtl/npu_pkg.sv
// Shared NPU types and constants for the systolic-array front end.
package npu_pkg;

    localparam int N_DIM  = 10;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } loader_state_t;

    typedef logic signed [DATA_W-1:0] elem_t;

endpackage

// File: rtl/mat_idx_counter.sv
// Row-major (row, col) index counter for an N x N matrix; clr dominates inc.
module mat_idx_counter #(
    parameter int N    = 10,
    parameter int IdxW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            clr,
    output logic [IdxW-1:0] row,
    output logic [IdxW-1:0] col,
    output logic            last
);

    logic [IdxW-1:0] row_q, row_d;
    logic [IdxW-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (inc) begin
            if (col_q == IdxW'(N - 1)) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == IdxW'(N - 1)) && (col_q == IdxW'(N - 1));

endmodule

// File: rtl/systolic_loader.sv
// Assembles a serial row-major stream into an N x N matrix, then starts the array and waits.
// Optional LOADER_LAST_CHECK_EN adds in_last framing checks with a sticky err flag.
module systolic_loader #(
    parameter int N      = npu_pkg::N_DIM,
    parameter int DATA_W = npu_pkg::DATA_W
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     in_valid,
    input  logic signed [DATA_W-1:0]                 in_data,
    output logic                                     in_ready,
    output logic signed [N-1:0][N-1:0][DATA_W-1:0]   A_out,
    output logic                                     sa_start,
    input  logic                                     sa_done,
    output logic                                     load_done,
    output logic                                     busy
`ifdef LOADER_LAST_CHECK_EN
    ,
    input  logic                                     in_last,
    output logic                                     err
`endif
);
    import npu_pkg::*;

    localparam int IdxW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] LOAD  = StLoad;
    localparam logic [1:0] START = StStart;
    localparam logic [1:0] WAIT  = StWait;
    localparam logic [1:0] DONE  = StDone;

    logic [1:0] state_q, state_d;
    logic signed [N-1:0][N-1:0][DATA_W-1:0] a_q, a_d;
    logic sa_done_q;
    logic [IdxW-1:0] row, col;
    logic idx_last, accept, final_beat, abort, idx_clr;

    assign accept     = in_valid && (state_q == LOAD);
    assign final_beat = accept && idx_last;

`ifdef LOADER_LAST_CHECK_EN
    logic err_q, err_d;

    // Early in_last restarts framing; a missing one on the final beat is only flagged.
    assign abort = accept && in_last && !idx_last;
    assign err_d = err_q | (accept && (in_last != idx_last));

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    assign abort = 1'b0;
`endif

    assign idx_clr = final_beat || abort;

    mat_idx_counter #(
        .N    (N),
        .IdxW (IdxW)
    ) u_idx (
        .clk  (clk),
        .rst  (rst),
        .inc  (accept),
        .clr  (idx_clr),
        .row  (row),
        .col  (col),
        .last (idx_last)
    );

    always_comb begin
        a_d = a_q;
        if (accept) a_d[row][col] = in_data;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (final_beat) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (sa_done && !sa_done_q) state_d = DONE;
            DONE:    state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOAD;
            a_q       <= '0;
            sa_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            sa_done_q <= sa_done;
        end
    end

    assign A_out     = a_q;
    assign in_ready  = (state_q == LOAD);
    assign sa_start  = (state_q == START);
    assign load_done = (state_q == DONE);
    assign busy      = (state_q != LOAD);

endmodule
